muldiv_sequencer: RTL
=====================

# muldiv_sequencer

Multi-cycle multiply/divide sequencer for the EX stage of the MIPS pipeline. It takes mult/multu/div/divu requests decoded from the R-type funct field and runs a 32-iteration shift-add multiplier or restoring divider. It holds a stall on the pipeline while working and owns the architectural HI/LO registers that mfhi/mflo read. The single-cycle ALU is unaffected; this block shares the EX operand buses with it.

## Interface
Parameters:
- none; width fixed at 32.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request valid; sampled only in IDLE or DONE
- func  in  6  funct code: 24 mult, 25 multu, 26 div, 27 divu; latched on accept
- src_a  in  32  rs operand (multiplicand / dividend); latched on accept
- src_b  in  32  rt operand (multiplier / divisor); latched on accept
- flush  in  1  abort an in-flight operation
- busy  out  1  high in CALC and FIX
- stall  out  1  equals busy; drives the hazard unit
- done  out  1  one-cycle pulse when HI/LO are updated
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- States: IDLE, CALC, FIX, DONE.
- Accept: start=1, flush=0, state in {IDLE, DONE}, and func in {24..27}.
  - Latch the operands. For signed ops, latch absolute values and the result signs.
  - Clear the 5-bit counter and go to CALC.
- Any other func with start=1 is ignored; the state does not change.
- CALC, multiply: 64-bit {acc, mplier} shift-add, one bit per cycle, LSB first.
- CALC, divide: restoring divide, one quotient bit per cycle, MSB first, with a 33-bit remainder subtract.
- Counter increments each CALC cycle. At count 31, go to FIX.
- FIX:
  - Signed mult: negate the 64-bit product if the operand signs differ.
  - Signed div: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - HI/LO are written at the end of FIX. Multiply writes HI = product[63:32], LO = product[31:0]. Divide writes HI = remainder, LO = quotient.
  - Then go to DONE.
- DONE: done=1 for one cycle. It behaves as IDLE for acceptance (back-to-back start allowed). With no accept, go to IDLE.
- Divide by zero, unsigned or signed: LO = 0xFFFFFFFF, HI = src_a as latched (original signed value). No sign fix is applied.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Flush:
  - In CALC or FIX, go to IDLE next cycle. HI/LO are unchanged and there is no done pulse.
  - In IDLE or DONE, flush blocks acceptance.
- start while busy is ignored and never queued.
- Reset: state IDLE, counter 0, busy/stall/done 0, hi/lo 0x00000000. Reset mid-operation discards all work; reset dominates flush and start.

## Timing
- Accept at edge T0. busy=1 from T0 through T0+33 edges: 32 CALC cycles plus 1 FIX cycle.
- HI/LO are valid and done=1 in the cycle after edge T0+33. Total latency is 34 cycles from accept to done.
- stall is combinational from state: no lag relative to busy.
- hi/lo are register outputs and are stable except at the FIX→DONE edge.
- Back-to-back: start during DONE gives busy=1 the next cycle, with no gap cycle.
- Flush asserted during cycle N gives busy=0 at cycle N+1.

## Configuration
- MULDIV_SIGNED_EN defined:
  - funct 24/26 perform two's-complement mult/div with FIX-stage sign correction, per the rules above.
- MULDIV_SIGNED_EN undefined:
  - funct 24/26 execute identically to 25/27 (unsigned); sign latching and negation logic are removed.
  - The FIX cycle remains as a pass-through, so latency is 34 cycles in both builds.

## Test plan
- multu 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. done exactly 34 cycles after accept; stall high for 33 cycles.
- mult −3 × 5 (0xFFFFFFFD, 0x00000005) → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
  - Without MULDIV_SIGNED_EN → HI=0x00000004, LO=0xFFFFFFF1.
- div −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Then immediately start divu 100 / 0 during DONE → accepted with no gap; LO=0xFFFFFFFF, HI=0x00000064.
- multu 6 × 7 with flush at CALC iteration 10 → busy=0 next cycle, no done, HI/LO keep prior values.
  - start during busy → ignored.
- rst asserted mid-CALC of divu → next cycle hi=lo=0, busy=done=0.
  - start with func=32 (add) in IDLE → no state change.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle mult/multu/div/divu unit for the EX stage.
// The unit runs a 32-iteration shift-add multiplier or restoring divider,
// stalls the pipeline while it works, and owns the HI/LO registers.
// Configuration macro: MULDIV_SIGNED_EN. When it is defined, funct 24/26 are
// signed with sign correction in the FIX cycle. When it is undefined, they
// alias the unsigned operations.
module muldiv_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  func,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [5:0] F_FIRST = 6'd24;  // mult
  localparam logic [5:0] F_LAST  = 6'd27;  // divu

  // Two's-complement negation, used for magnitudes and sign correction.
  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    return ~v + 64'd1;
  endfunction

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  // Holds the multiply high accumulator or the divide partial remainder.
  logic [31:0] acc_q, acc_d;
  // Holds the multiplier (shifted right) or the dividend turning into the quotient.
  logic [31:0] work_q, work_d;
  // Holds the multiplicand or divisor magnitude.
  logic [31:0] opb_q, opb_d;
  // Holds the dividend as presented. HI takes this value on divide by zero.
  logic [31:0] orig_a_q, orig_a_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
`ifdef MULDIV_SIGNED_EN
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
`endif

  logic        idle_like;
  logic        func_ok;
  logic        accept;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [63:0] fix_res;
`ifdef MULDIV_SIGNED_EN
  logic        op_signed;
  logic        sign_a;
  logic        sign_b;
`endif

  assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
  assign func_ok   = (func >= F_FIRST) && (func <= F_LAST);
  assign accept    = start && !flush && idle_like && func_ok;

  // Compute operand magnitudes and result signs to latch on accept.
  always_comb begin
`ifdef MULDIV_SIGNED_EN
    op_signed = (func == 6'd24) || (func == 6'd26);
    sign_a    = op_signed && src_a[31];
    sign_b    = op_signed && src_b[31];
    if (sign_a) begin
      mag_a = neg32(src_a);
    end else begin
      mag_a = src_a;
    end
    if (sign_b) begin
      mag_b = neg32(src_b);
    end else begin
      mag_b = src_b;
    end
`else
    mag_a = src_a;
    mag_b = src_b;
`endif
  end

  // Compute one iteration step: add-and-shift for multiply, trial subtract for divide.
  always_comb begin
    if (work_q[0]) begin
      mul_sum = {1'b0, acc_q} + {1'b0, opb_q};
    end else begin
      mul_sum = {1'b0, acc_q};
    end
    div_shift = {acc_q, work_q[31]};
    div_ge    = (div_shift >= {1'b0, opb_q});
  end

  // Build the final 64-bit {HI, LO} value, applying sign correction and divide by zero.
  always_comb begin
    if (!is_div_q) begin
`ifdef MULDIV_SIGNED_EN
      if (neg_res_q) begin
        fix_res = neg64({acc_q, work_q});
      end else begin
        fix_res = {acc_q, work_q};
      end
`else
      fix_res = {acc_q, work_q};
`endif
    end else if (opb_q == 32'd0) begin
      fix_res = {orig_a_q, 32'hFFFF_FFFF};
    end else begin
`ifdef MULDIV_SIGNED_EN
      fix_res[63:32] = neg_rem_q ? neg32(acc_q) : acc_q;
      fix_res[31:0]  = neg_res_q ? neg32(work_q) : work_q;
`else
      fix_res = {acc_q, work_q};
`endif
    end
  end

  // Sequencer next-state and datapath register updates.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    acc_d    = acc_q;
    work_d   = work_q;
    opb_d    = opb_q;
    orig_a_d = orig_a_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
`ifdef MULDIV_SIGNED_EN
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_d  = S_CALC;
          cnt_d    = 5'd0;
          is_div_d = func[1];
          acc_d    = 32'd0;
          work_d   = mag_a;
          opb_d    = mag_b;
          orig_a_d = src_a;
`ifdef MULDIV_SIGNED_EN
          neg_res_d = sign_a ^ sign_b;
          neg_rem_d = sign_a;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          if (is_div_q) begin
            if (div_ge) begin
              acc_d = div_shift[31:0] - opb_q;
            end else begin
              acc_d = div_shift[31:0];
            end
            work_d = {work_q[30:0], div_ge};
          end else begin
            acc_d  = mul_sum[32:1];
            work_d = {mul_sum[0], work_q[31:1]};
          end
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d = S_FIX;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_FIX: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
          hi_d    = fix_res[63:32];
          lo_d    = fix_res[31:0];
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset that dominates flush and start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      is_div_q <= 1'b0;
      acc_q    <= 32'd0;
      work_q   <= 32'd0;
      opb_q    <= 32'd0;
      orig_a_q <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      done_q   <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      acc_q    <= acc_d;
      work_q   <= work_d;
      opb_q    <= opb_d;
      orig_a_q <= orig_a_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
`ifdef MULDIV_SIGNED_EN
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

  assign busy  = (state_q == S_CALC) || (state_q == S_FIX);
  assign stall = busy;
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule
